// File: rtl/deflate_pkg.sv
// Shared definitions for the static-Huffman deflate path: packer states,
// default widths and the code-beat bundle passed between encoder stages.
package deflate_pkg;

    localparam int DEFLATE_MAX_CODE_W = 18;
    localparam int DEFLATE_OUT_W      = 32;
    localparam int DEFLATE_LEN_W      = 5;

    typedef enum logic [1:0] {
        S_RUN,
        S_FLUSH,
        S_LAST
    } packer_state_t;

    typedef struct packed {
        logic [DEFLATE_MAX_CODE_W-1:0] code;
        logic [DEFLATE_LEN_W-1:0]      len;
        logic                          last;
    } code_beat_t;

endpackage

// File: rtl/deflate_bit_packer_bit_mask_gen.sv
// Combinational "keep the low len bits" mask: bit i is set when i < len.
module bit_mask_gen #(
    parameter int W     = 18,
    parameter int LEN_W = 5
) (
    input  logic [LEN_W-1:0] len,
    output logic [W-1:0]     mask
);

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_bit
            assign mask[gi] = (len > LEN_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/deflate_bit_packer.sv
// Packs LSB-first variable-length codes into OUT_W-bit words with end-of-block
// flush. Define DEFLATE_PACKER_STATS_EN to add bit/word handoff counters.
module deflate_bit_packer
    import deflate_pkg::*;
#(
    parameter int MAX_CODE_W = DEFLATE_MAX_CODE_W,
    parameter int OUT_W      = DEFLATE_OUT_W,
    parameter int LEN_W      = DEFLATE_LEN_W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [MAX_CODE_W-1:0]            code_in,
    input  logic [LEN_W-1:0]                 code_len_in,
    input  logic                             code_last_in,
    input  logic                             code_valid_in,
    output logic                             code_ready_out,
    output logic [OUT_W-1:0]                 word_out,
    output logic [$clog2(OUT_W/8):0]         word_bytes_out,
    output logic                             word_last_out,
    output logic                             word_valid_out,
`ifdef DEFLATE_PACKER_STATS_EN
    output logic [31:0]                      bit_count_out,
    output logic [15:0]                      word_count_out,
`endif
    input  logic                             word_ready_in
);

    localparam int ACC_W   = OUT_W + MAX_CODE_W;
    localparam int FILL_W  = $clog2(ACC_W) + 1;
    localparam int BYTES_W = $clog2(OUT_W/8) + 1;
    localparam logic [FILL_W-1:0]  OUT_W_F    = FILL_W'(OUT_W);
    localparam logic [BYTES_W-1:0] FULL_BYTES = BYTES_W'(OUT_W/8);

    packer_state_t        state_q, state_d;
    logic [ACC_W-1:0]     acc_q, acc_d, acc_mid;
    logic [FILL_W-1:0]    fill_q, fill_d, fill_mid;
    logic [OUT_W-1:0]     word_q, word_d;
    logic [BYTES_W-1:0]   bytes_q, bytes_d;
    logic                 last_q, last_d;
    logic                 valid_q, valid_d;

    logic [LEN_W-1:0]      len_sat;
    logic [MAX_CODE_W-1:0] code_mask;
    logic [OUT_W-1:0]      keep_mask;
    logic                  slot_free, drain, accept;

    assign len_sat = (code_len_in > LEN_W'(MAX_CODE_W)) ? LEN_W'(MAX_CODE_W) : code_len_in;

    bit_mask_gen #(.W(MAX_CODE_W), .LEN_W(LEN_W)) u_code_mask (
        .len  (len_sat),
        .mask (code_mask)
    );

    bit_mask_gen #(.W(OUT_W), .LEN_W(FILL_W)) u_keep_mask (
        .len  (fill_q),
        .mask (keep_mask)
    );

    assign code_ready_out = (state_q == S_RUN) && (fill_q <= OUT_W_F);
    assign slot_free      = !valid_q || word_ready_in;
    assign drain          = (fill_q >= OUT_W_F) && slot_free;
    assign accept         = code_valid_in && code_ready_out;

    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        bytes_d  = bytes_q;
        last_d   = last_q;
        valid_d  = slot_free ? 1'b0 : valid_q;
        acc_mid  = acc_q;
        fill_mid = fill_q;

        if (drain) begin
            word_d   = acc_q[OUT_W-1:0];
            bytes_d  = FULL_BYTES;
            last_d   = 1'b0;
            valid_d  = 1'b1;
            acc_mid  = acc_q >> OUT_W;
            fill_mid = fill_q - OUT_W_F;
        end
        acc_d  = acc_mid;
        fill_d = fill_mid;

        case (state_q)
            S_RUN: begin
                if (accept) begin
                    acc_d  = acc_mid | (ACC_W'(code_in & code_mask) << fill_mid);
                    fill_d = fill_mid + FILL_W'(len_sat);
                    if (code_last_in) begin
                        // Block ends exactly on the word being drained now:
                        // that word is the last one, no empty word follows.
                        if (drain && (fill_d == '0)) begin
                            last_d  = 1'b1;
                            state_d = S_LAST;
                        end else begin
                            state_d = S_FLUSH;
                        end
                    end
                end
            end
            S_FLUSH: begin
                if (drain) begin
                    if (fill_mid == '0) begin
                        last_d  = 1'b1;
                        state_d = S_LAST;
                    end
                end else if (slot_free) begin
                    word_d  = acc_q[OUT_W-1:0] & keep_mask;
                    bytes_d = BYTES_W'((fill_q + FILL_W'(7)) >> 3);
                    last_d  = 1'b1;
                    valid_d = 1'b1;
                    acc_d   = '0;
                    fill_d  = '0;
                    state_d = S_LAST;
                end
            end
            S_LAST: begin
                if (valid_q && word_ready_in) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            acc_q   <= '0;
            fill_q  <= '0;
            word_q  <= '0;
            bytes_q <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            fill_q  <= fill_d;
            word_q  <= word_d;
            bytes_q <= bytes_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    assign word_out       = word_q;
    assign word_bytes_out = bytes_q;
    assign word_last_out  = last_q;
    assign word_valid_out = valid_q;

`ifdef DEFLATE_PACKER_STATS_EN
    logic [31:0] bit_count_q, bit_count_d;
    logic [15:0] word_count_q, word_count_d;

    always_comb begin
        bit_count_d  = bit_count_q + (accept ? 32'(len_sat) : 32'd0);
        word_count_d = word_count_q + ((valid_q && word_ready_in) ? 16'd1 : 16'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_count_q  <= '0;
            word_count_q <= '0;
        end else begin
            bit_count_q  <= bit_count_d;
            word_count_q <= word_count_d;
        end
    end

    assign bit_count_out  = bit_count_q;
    assign word_count_out = word_count_q;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            assert (code_len_in <= LEN_W'(MAX_CODE_W))
                else $error("code_len_in %0d exceeds MAX_CODE_W", code_len_in);
        end
    end
`endif

endmodule

// File: tb/tb_deflate_bit_packer.sv
// Scoreboard bench for deflate_bit_packer: expected words are queued per block
// from a bit-stream reference model and popped by an independent output monitor.
module tb_deflate_bit_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] code_in;
    logic [4:0]  code_len_in;
    logic        code_last_in;
    logic        code_valid_in;
    logic        code_ready_out;
    logic [31:0] word_out;
    logic [2:0]  word_bytes_out;
    logic        word_last_out;
    logic        word_valid_out;
    logic        word_ready_in;
`ifdef DEFLATE_PACKER_STATS_EN
    logic [31:0] bit_count_out;
    logic [15:0] word_count_out;
`endif

    deflate_bit_packer dut (
        .clk            (clk),
        .rst            (rst),
        .code_in        (code_in),
        .code_len_in    (code_len_in),
        .code_last_in   (code_last_in),
        .code_valid_in  (code_valid_in),
        .code_ready_out (code_ready_out),
        .word_out       (word_out),
        .word_bytes_out (word_bytes_out),
        .word_last_out  (word_last_out),
        .word_valid_out (word_valid_out),
`ifdef DEFLATE_PACKER_STATS_EN
        .bit_count_out  (bit_count_out),
        .word_count_out (word_count_out),
`endif
        .word_ready_in  (word_ready_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  bytes;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          bp_mode = 0;   // 0 always ready, 1 random, 2 held low
    logic [17:0] blk_code[16];
    logic [4:0]  blk_len[16];
    int          blk_n;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic void push_exp(input logic [31:0] d, input logic [2:0] b, input logic l);
        exp_t e;
        e.data = d; e.bytes = b; e.last = l;
        sb.push_back(e);
    endfunction

    // Reference: concatenate the block's valid bits, cut into 32-bit words.
    function automatic void model_block();
        bit q[$];
        for (int i = 0; i < blk_n; i++)
            for (int b = 0; b < int'(blk_len[i]); b++)
                q.push_back(blk_code[i][b]);
        if (q.size() == 0) begin
            push_exp(32'h0, 3'd0, 1'b1);
        end else begin
            while (q.size() > 0) begin
                int n;
                logic [31:0] w;
                n = (q.size() > 32) ? 32 : q.size();
                w = '0;
                for (int i = 0; i < n; i++) w[i] = q.pop_front();
                push_exp(w, (q.size() == 0) ? 3'((n + 7) / 8) : 3'd4, q.size() == 0);
            end
        end
    endfunction

    // Caller must be at posedge+#1; returns at posedge+#1 after acceptance.
    task automatic send_beat(input logic [17:0] c, input logic [4:0] l, input logic la);
        bit ok;
        ok = 1'b0;
        code_in = c; code_len_in = l; code_last_in = la; code_valid_in = 1'b1;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk);
            ok = code_ready_out;
        end
        @(posedge clk); #1;
        code_valid_in = 1'b0; code_last_in = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL beat_timeout actual=ready_low required=accept code=%0h len=%0d", c, l);
        end
    endtask

    task automatic send_block(input bit gaps);
        for (int i = 0; i < blk_n; i++) begin
            send_beat(blk_code[i], blk_len[i], i == blk_n - 1);
            if (gaps && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_drain(input string name);
        for (int n = 0; n < 2000 && sb.size() != 0; n++) @(negedge clk);
        check(name, 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_idle(input string name);
        @(negedge clk);
        check(name, {word_valid_out, word_last_out, word_bytes_out, word_out, code_ready_out},
              {1'b0, 1'b0, 3'd0, 32'd0, 1'b1});
        @(posedge clk); #1;
    endtask

    // Downstream backpressure driver
    initial begin
        word_ready_in = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (bp_mode)
                0:       word_ready_in = 1'b1;
                1:       word_ready_in = ($urandom_range(0, 3) != 0);
                default: word_ready_in = 1'b0;
            endcase
        end
    end

    // Output monitor: pops the scoreboard on every handoff, checks hold under stall
    initial begin
        logic        stall_prev;
        logic [31:0] pw;
        logic [2:0]  pb;
        logic        pl;
        exp_t        e;
        stall_prev = 1'b0; pw = '0; pb = '0; pl = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev)
                    check("hold", {word_valid_out, word_last_out, word_bytes_out, word_out},
                          {1'b1, pl, pb, pw});
                if (word_valid_out && word_ready_in) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_word actual=%0h bytes=%0d last=%0b required=none",
                                 word_out, word_bytes_out, word_last_out);
                    end else begin
                        e = sb.pop_front();
                        check("word", {word_last_out, word_bytes_out, word_out},
                              {e.last, e.bytes, e.data});
                    end
                end
                stall_prev = word_valid_out && !word_ready_in;
                pw = word_out; pb = word_bytes_out; pl = word_last_out;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit saw_low;
`ifdef DEFLATE_PACKER_STATS_EN
        logic [31:0] bc0;
        logic [15:0] wc0;
`endif
        rst = 1'b1;
        code_in = '0; code_len_in = '0; code_last_in = 1'b0; code_valid_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_idle("reset_state");
`ifdef DEFLATE_PACKER_STATS_EN
        check("reset_stats", {bit_count_out, word_count_out}, 64'd0);
`endif

        // Four 7-bit codes, the last one flagged
        push_exp(32'h08102040, 3'd4, 1'b1);
        for (int i = 0; i < 4; i++) send_beat(18'h40, 5'd7, i == 3);
        wait_drain("drain_case1");

        // 36 one-bits split into a full word and a 4-bit tail
        push_exp(32'hFFFFFFFF, 3'd4, 1'b0);
        push_exp(32'h0000000F, 3'd1, 1'b1);
        send_beat(18'h3FFFF, 5'd18, 1'b0);
        send_beat(18'h3FFFF, 5'd18, 1'b1);
        wait_drain("drain_case2");

        // Exactly 32 bits: one last word, no trailing empty word
        push_exp(32'hF00F3CA5, 3'd4, 1'b1);
        send_beat(18'h000A5, 5'd8, 1'b0);
        send_beat(18'h0003C, 5'd8, 1'b0);
        send_beat(18'h0000F, 5'd8, 1'b0);
        send_beat(18'h000F0, 5'd8, 1'b1);
        wait_drain("drain_exact32");

        // Empty block
        push_exp(32'h0, 3'd0, 1'b1);
        send_beat(18'h2ABCD, 5'd0, 1'b1);
        wait_drain("drain_empty");

        // Bits above the length are masked off
`ifdef DEFLATE_PACKER_STATS_EN
        bc0 = bit_count_out; wc0 = word_count_out;
`endif
        push_exp(32'h1F, 3'd1, 1'b1);
        send_beat(18'h003FF, 5'd5, 1'b1);
`ifdef DEFLATE_PACKER_STATS_EN
        check("bit_count_delta", 64'(bit_count_out - bc0), 64'd5);
`endif
        wait_drain("drain_mask");
`ifdef DEFLATE_PACKER_STATS_EN
        check("word_count_delta", 64'(word_count_out - wc0), 64'd1);
`endif

        // Output stalled for 10 cycles under continuous 18-bit beats
        blk_n = 6;
        for (int i = 0; i < blk_n; i++) begin
            blk_code[i] = 18'($urandom);
            blk_len[i]  = 5'd18;
        end
        model_block();
        bp_mode = 2;
        saw_low = 1'b0;
        fork
            send_block(1'b0);
            begin
                repeat (10) begin
                    @(negedge clk);
                    if (!code_ready_out) saw_low = 1'b1;
                end
                bp_mode = 0;
            end
        join
        check("ready_drop", 64'(saw_low), 64'd1);
        wait_drain("drain_stall");

        // Reset mid-block with 20 bits held and a stalled word pending
        bp_mode = 2;
        @(posedge clk); #1;
        send_beat(18'h12345, 5'd18, 1'b0);
        send_beat(18'h0ABCD, 5'd18, 1'b0);
        send_beat(18'h0FFFF, 5'd16, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bp_mode = 0;
        check_idle("reset_mid");
`ifdef DEFLATE_PACKER_STATS_EN
        check("reset_mid_stats", {bit_count_out, word_count_out}, 64'd0);
`endif
        push_exp(32'h08102040, 3'd4, 1'b1);
        for (int i = 0; i < 4; i++) send_beat(18'h40, 5'd7, i == 3);
        wait_drain("drain_after_reset");

        // Random blocks under random backpressure
        bp_mode = 1;
        for (int b = 0; b < 40; b++) begin
            blk_n = $urandom_range(1, 12);
            for (int i = 0; i < blk_n; i++) begin
                blk_code[i] = 18'($urandom);
                if (i == blk_n - 1)
                    blk_len[i] = 5'($urandom_range(1, 18));
                else
                    blk_len[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 18));
            end
            model_block();
            send_block(1'b1);
        end
        bp_mode = 0;
        wait_drain("drain_random");
        repeat (20) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
